// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared types for the instruction fetch stage
package cpu_pkg;
  localparam int WORD_W = 32;

  typedef enum logic {RUN, FLUSH} fetch_state_t;

  typedef struct packed {
    logic [WORD_W-1:0] instr;
    logic [WORD_W-1:0] pc;
  } entry_t;
endpackage

// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - instruction memory and decode-side signals of the fetch stage
interface fetch_unit_if;
  import cpu_pkg::*;

  logic              imem_req;
  logic [WORD_W-1:0] imem_addr;
  logic              imem_gnt;
  logic              imem_rvalid;
  logic [WORD_W-1:0] imem_rdata;
  logic              instr_valid;
  logic [WORD_W-1:0] instr;
  logic [WORD_W-1:0] instr_pc;
  logic              decode_ready;
  logic              redirect;
  logic [WORD_W-1:0] redirect_pc;

  modport master (
    output imem_req, imem_addr, instr_valid, instr, instr_pc,
    input  imem_gnt, imem_rvalid, imem_rdata, decode_ready, redirect, redirect_pc
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, instr, instr_pc,
    output imem_gnt, imem_rvalid, imem_rdata, decode_ready, redirect, redirect_pc
  );
endinterface

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - small in-order FIFO with synchronous clear
module fetch_queue #(
  parameter int  DEPTH = 2,
  parameter type T     = logic [31:0],
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      push,
  input  T          push_data,
  input  logic      pop,
  input  logic      clear,
  output logic [AW:0] count,
  output T          head
);
  T              mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  always_comb begin
    do_push  = push && !clear;
    do_pop   = pop && (count_q != '0) && !clear;
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    count_d  = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // A push is only legal with room before this cycle's pop is taken into account.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
    if (!rst && do_push) begin
      assert (count_q < (AW+1)'(DEPTH));
    end
  end

  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];
endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - PC, credit accounting, flush FSM and memory interface of instruction fetch
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int                DEPTH    = 2,
  parameter logic [WORD_W-1:0] RESET_PC = 32'h0000_0000
) (
  input logic          clk,
  input logic          reset,
  fetch_unit_if.master bus
);
  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_t      state_q, state_d;
  logic [WORD_W-1:0] pc_q, pc_d;
  logic [CW-1:0]     outst_q, outst_d, stale_q, stale_d;
  logic [CW-1:0]     q_count, tag_count;
  entry_t            q_head, q_push_data;
  logic [WORD_W-1:0] tag_head;
  logic              q_push, tag_push, tag_pop, flush;
  logic              q_valid, instr_fire, req, issue;
  logic [CW:0]       credit_used;

  assign q_valid    = (q_count != '0);
  assign instr_fire = q_valid && bus.decode_ready;
  // The slot freed by this cycle's pop is reusable at once, so a full pipe keeps one word per cycle.
  assign credit_used = {1'b0, q_count} + {1'b0, outst_q} - (CW+1)'(instr_fire);
  assign req         = !reset && (state_q == RUN) && (credit_used < (CW+1)'(DEPTH));
  assign issue       = req && bus.imem_gnt;
  assign q_push_data = '{instr: bus.imem_rdata, pc: tag_head};

  assign bus.imem_req    = req;
  assign bus.imem_addr   = pc_q;
  assign bus.instr_valid = q_valid;
  assign bus.instr       = q_valid ? q_head.instr : '0;
  assign bus.instr_pc    = q_valid ? q_head.pc : '0;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    outst_d  = outst_q;
    stale_d  = stale_q;
    q_push   = 1'b0;
    tag_push = 1'b0;
    tag_pop  = 1'b0;
    flush    = 1'b0;
    if (bus.redirect) begin
      flush   = 1'b1;
      pc_d    = {bus.redirect_pc[WORD_W-1:2], 2'b00};
      stale_d = outst_q + CW'(issue) - CW'(bus.imem_rvalid);
      outst_d = stale_d;
      state_d = (stale_d != '0) ? FLUSH : RUN;
    end else begin
      case (state_q)
        RUN: begin
          tag_push = issue;
          q_push   = bus.imem_rvalid;
          tag_pop  = bus.imem_rvalid;
          outst_d  = outst_q + CW'(issue) - CW'(bus.imem_rvalid);
          if (issue) begin
            pc_d = pc_q + 32'd4;
          end
        end
        FLUSH: begin
          if (bus.imem_rvalid) begin
            stale_d = stale_q - CW'(1);
            outst_d = outst_q - CW'(1);
            if (stale_d == '0) begin
              state_d = RUN;
            end
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
      outst_q <= '0;
      stale_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      outst_q <= outst_d;
      stale_q <= stale_d;
    end
  end

  // In RUN every in-flight request owns exactly one address tag.
  always_ff @(posedge clk) begin
    if (!reset && state_q == RUN) begin
      assert (tag_count == outst_q);
    end
  end

  fetch_queue #(.DEPTH(DEPTH), .T(entry_t)) u_instr_q (
    .clk       (clk),
    .rst       (reset),
    .push      (q_push),
    .push_data (q_push_data),
    .pop       (instr_fire),
    .clear     (flush),
    .count     (q_count),
    .head      (q_head)
  );

  fetch_queue #(.DEPTH(DEPTH), .T(logic [WORD_W-1:0])) u_tag_q (
    .clk       (clk),
    .rst       (reset),
    .push      (tag_push),
    .push_data (pc_q),
    .pop       (tag_pop),
    .clear     (flush),
    .count     (tag_count),
    .head      (tag_head)
  );
endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - scoreboard bench for fetch_unit against an in-order memory and address-stream model
module tb_fetch_unit;
  import cpu_pkg::*;

  localparam int          DEPTH    = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  fetch_unit_if bus();

  fetch_unit #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          lat = 1;
  int          last_due = 0;
  bit          redir_prev = 1'b0;
  logic [31:0] model_pc = RESET_PC;
  mreq_t       mem_q[$];
  logic [31:0] exp_q[$];

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req_v);
    checks++;
    if (act !== req_v) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, req_v, $time);
    end
  endtask

  task automatic step(input bit g, input bit r, input bit rd, input logic [31:0] tgt);
    @(posedge clk);
    #1;
    reset = 1'b0;
    cyc++;
    if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata  = word_of(mem_q[0].addr);
      void'(mem_q.pop_front());
    end else begin
      bus.imem_rvalid = 1'b0;
      bus.imem_rdata  = $urandom;
    end
    bus.imem_gnt     = g;
    bus.decode_ready = r;
    bus.redirect     = rd;
    bus.redirect_pc  = rd ? tgt : $urandom;
  endtask

  task automatic mid_cycle_reset();
    @(negedge clk);
    #3;
    reset = 1'b1;
    #1;
    check("rst_imem_req", 32'(bus.imem_req), 0);
    check("rst_instr_valid", 32'(bus.instr_valid), 0);
    check("rst_instr", bus.instr, 0);
    check("rst_instr_pc", bus.instr_pc, 0);
    check("rst_state", 32'(dut.state_q), 32'(RUN));
    check("rst_stale", 32'(dut.stale_q), 0);
    mem_q.delete();
    exp_q.delete();
    model_pc   = RESET_PC;
    last_due   = cyc;
    redir_prev = 1'b0;
  endtask

  // Issue tracker: expected address stream, memory model and expected-response queue.
  always begin
    @(negedge clk);
    #2;
    if (!reset) begin
      if (bus.imem_req && bus.imem_gnt) begin
        int due;
        check("imem_addr", bus.imem_addr, model_pc);
        due = cyc + lat;
        if (due <= last_due) due = last_due + 1;
        last_due = due;
        mem_q.push_back('{addr: bus.imem_addr, due: due});
        if (!bus.redirect) exp_q.push_back(model_pc);
        model_pc = model_pc + 32'd4;
      end
      check("inflight_le_depth", 32'(mem_q.size() <= DEPTH), 1);
      if (bus.redirect) begin
        exp_q.delete();
        model_pc   = bus.redirect_pc & 32'hFFFF_FFFC;
        redir_prev = 1'b1;
      end else begin
        redir_prev = 1'b0;
      end
    end
  end

  // Output monitor: pops the scoreboard on every decode handshake.
  always @(negedge clk) begin
    if (!reset) begin
      if (redir_prev) check("no_valid_after_redirect", 32'(bus.instr_valid), 0);
      if (bus.instr_valid) begin
        check("exp_queue_nonempty", 32'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          check("instr_pc", bus.instr_pc, exp_q[0]);
          check("instr", bus.instr, word_of(exp_q[0]));
          if (bus.decode_ready) void'(exp_q.pop_front());
        end
      end else begin
        check("idle_outputs_zero", bus.instr | bus.instr_pc, 0);
      end
    end
  end

  initial begin
    bus.imem_gnt     = 1'b0;
    bus.imem_rvalid  = 1'b0;
    bus.imem_rdata   = '0;
    bus.decode_ready = 1'b0;
    bus.redirect     = 1'b0;
    bus.redirect_pc  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_imem_req", 32'(bus.imem_req), 0);
    check("reset_instr_valid", 32'(bus.instr_valid), 0);
    check("reset_instr", bus.instr, 0);
    check("reset_instr_pc", bus.instr_pc, 0);

    // Latency and bubble-free streaming with a 1-cycle memory.
    lat = 1;
    for (int i = 0; i < 14; i++) begin
      step(1'b1, 1'b1, 1'b0, 32'h0);
      @(negedge clk);
      check("latency_valid", 32'(bus.instr_valid), 32'(i >= 2));
    end

    // Decode stall: queue fills, requests stop, order preserved afterwards.
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    check("stall_req_low", 32'(bus.imem_req), 0);
    check("stall_queue_full", 32'(dut.q_count), DEPTH);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b0, 32'h0);

    // Redirect with two requests in flight on a 3-cycle memory.
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b0, 32'h0);
    lat = 3;
    step(1'b1, 1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b1, 1'b1, 32'h0000_0103);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    @(negedge clk);
    check("flush_state", 32'(dut.state_q), 32'(FLUSH));
    check("flush_req_low", 32'(bus.imem_req), 0);
    for (int i = 0; i < 12; i++) step(1'b1, 1'b1, 1'b0, 32'h0);

    // Redirect coinciding with a response and a decode pop.
    lat = 1;
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b1, 1'b1, 32'h0000_0200);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    @(negedge clk);
    check("queue_empty_after_redirect", 32'(dut.q_count), 0);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b0, 32'h0);

    // PC wrap past the top of the address space.
    step(1'b1, 1'b1, 1'b1, 32'hFFFF_FFF8);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b0, 32'h0);

    // Randomised traffic.
    for (int i = 0; i < 1500; i++) begin
      logic [31:0] tgt;
      if (i % 50 == 0) lat = $urandom_range(1, 4);
      tgt = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
      step(($urandom_range(0, 3) != 0), ($urandom_range(0, 9) < 7), ($urandom_range(0, 99) < 3), tgt);
    end

    // Reset with a full queue, then restart from RESET_PC.
    lat = 4;
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    check("pre_reset_queue_full", 32'(dut.q_count), DEPTH);
    mid_cycle_reset();
    for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b0, 32'h0);

    // Reset while a flush is pending.
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    step(1'b0, 1'b1, 1'b1, 32'h0000_0040);
    step(1'b0, 1'b1, 1'b0, 32'h0);
    @(negedge clk);
    check("pre_reset_flush", 32'(dut.state_q), 32'(FLUSH));
    mid_cycle_reset();
    lat = 1;
    for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 1'b0, 32'h0);

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
